mac_dot: RTL



---
 rtl/mac_pkg.sv | 26 ++
 rtl/mac_sat_add.sv | 37 +++
 rtl/mac_dot.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and saturation limits for the dot-product engine family.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Largest unsigned value in w bits.
  function automatic logic [63:0] umax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Largest two's-complement value in w bits.
  function automatic logic [63:0] smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value in w bits (low w bits are the pattern).
  function automatic logic [63:0] smin(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational (SWIDTH+1)-bit add with clamp to SWIDTH bits, signed or unsigned.
// Operands arrive already extended, so the raw sum never wraps in SWIDTH+1 bits.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int SWIDTH = 10
) (
  input  logic              signed_i,
  input  logic [SWIDTH:0]   a_i,
  input  logic [SWIDTH:0]   b_i,
  output logic [SWIDTH-1:0] sum_o,
  output logic              ovf_o
);

  localparam logic [SWIDTH-1:0] UMAX = SWIDTH'(umax(SWIDTH));
  localparam logic [SWIDTH-1:0] SMAX = SWIDTH'(smax(SWIDTH));
  localparam logic [SWIDTH-1:0] SMIN = SWIDTH'(smin(SWIDTH));

  logic [SWIDTH:0] raw;

  // Add, then clamp when the result leaves the SWIDTH-bit range of the mode.
  always_comb begin
    raw   = a_i + b_i;
    sum_o = raw[SWIDTH-1:0];
    ovf_o = 1'b0;
    if (signed_i) begin
      if (raw[SWIDTH] != raw[SWIDTH-1]) begin
        ovf_o = 1'b1;
        sum_o = raw[SWIDTH] ? SMIN : SMAX;
      end
    end else if (raw[SWIDTH]) begin
      ovf_o = 1'b1;
      sum_o = UMAX;
    end
  end

endmodule

// File: rtl/mac_dot.sv
// Pipelined saturating dot-product engine: multiply stage, accumulate stage,
// result held in HOLD until the downstream handshake.
module mac_dot
  import mac_pkg::*;
#(
  parameter int IWIDTH = 4,
  parameter int SWIDTH = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              signed_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] a_i,
  input  logic [IWIDTH-1:0] b_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SWIDTH-1:0] sum_o,
  output logic              ovf_o
);

  localparam int PW = 2 * IWIDTH;
  localparam int XW = SWIDTH + 1 - PW;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              drn_q, drn_d;
  logic              prod_vld_q, prod_vld_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [SWIDTH-1:0] acc_q, acc_d;

  logic [PW-1:0]     ax, bx;
  logic [SWIDTH:0]   prod_x, acc_x;
  logic [SWIDTH-1:0] sat_sum;
  logic              sat_ovf, accept, mul_sgn;

  // A beat offered during clr or rst is refused rather than silently lost.
  assign in_ready  = ~rst & ~clr & ((state_q == IDLE) || (state_q == ACC));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign sum_o     = acc_q;
  assign ovf_o     = ovf_q;

  // Operand/product extension; the first beat multiplies in the live mode
  // because the latched mode only lands on that same edge.
  always_comb begin
    mul_sgn = (state_q == IDLE) ? signed_i : mode_q;
    ax      = mul_sgn ? {{IWIDTH{a_i[IWIDTH-1]}}, a_i} : {{IWIDTH{1'b0}}, a_i};
    bx      = mul_sgn ? {{IWIDTH{b_i[IWIDTH-1]}}, b_i} : {{IWIDTH{1'b0}}, b_i};
    prod_x  = mode_q ? {{XW{prod_q[PW-1]}}, prod_q} : {{XW{1'b0}}, prod_q};
    acc_x   = mode_q ? {acc_q[SWIDTH-1], acc_q} : {1'b0, acc_q};
  end

  mac_sat_add #(.SWIDTH(SWIDTH)) u_sat (
    .signed_i (mode_q),
    .a_i      (acc_x),
    .b_i      (prod_x),
    .sum_o    (sat_sum),
    .ovf_o    (sat_ovf)
  );

  // Next-state: FSM, term counter, pipeline stages; clr overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    drn_d      = drn_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = prod_vld_q ? sat_sum : acc_q;
    ovf_d      = ovf_q | (prod_vld_q & sat_ovf);

    if (accept) begin
      prod_d     = ax * bx;
      prod_vld_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d  = signed_i;
          cnt_d   = len_i;
          state_d = (len_i == '0) ? DRAIN : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        drn_d = ~drn_q;
        if (drn_q) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d    = IDLE;
      cnt_d      = '0;
      mode_d     = 1'b0;
      drn_d      = 1'b0;
      prod_d     = '0;
      prod_vld_d = 1'b0;
      acc_d      = '0;
      ovf_d      = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      drn_q      <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      drn_q      <= drn_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
